// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, FSM states,
// datapath mux selects and the bundled control word driven by the main FSM.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef enum logic [2:0] {
      OPC_LOAD,
      OPC_STORE,
      OPC_RTYPE,
      OPC_ITYPE,
      OPC_BEQ,
      OPC_JAL,
      OPC_ILLEGAL
   } op_class_e;

   typedef struct packed {
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       instr_done;
   } ctrl_t;

   // FETCH control word; also what the outputs show while reset is held.
   function automatic ctrl_t fetch_ctrl();
      ctrl_t c;
      c            = '0;
      c.ir_write   = 1'b1;
      c.alu_src_a  = SRCA_PC;
      c.alu_src_b  = SRCB_FOUR;
      c.alu_op     = ALUOP_ADD;
      c.result_src = RES_ALU;
      c.pc_update  = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: instruction class, immediate format and an
// unsupported-opcode flag for the main control FSM.
module instr_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] op_i,
   output op_class_e  op_class_o,
   output logic [1:0] imm_src_o,
   output logic       illegal_o
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      op_class_o = OPC_ILLEGAL;
      imm_src_o  = IMM_I;
      case (op_i)
         OP_LW: begin
            op_class_o = OPC_LOAD;
            imm_src_o  = IMM_I;
         end
         OP_SW: begin
            op_class_o = OPC_STORE;
            imm_src_o  = IMM_S;
         end
         OP_R:   op_class_o = OPC_RTYPE;
         OP_I: begin
            op_class_o = OPC_ITYPE;
            imm_src_o  = IMM_I;
         end
         OP_BEQ: begin
            op_class_o = OPC_BEQ;
            imm_src_o  = IMM_B;
         end
         OP_JAL: begin
            op_class_o = OPC_JAL;
            imm_src_o  = IMM_J;
         end
         default: ;
      endcase
   end

   assign illegal_o = (op_class_o == OPC_ILLEGAL);

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback and driving datapath enables and muxes.
module main_control_fsm
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic       regWrite,
   output logic [1:0] immSrc,
   output logic       instrDone,
   output logic       illegalOp
);

   state_e    state_q, state_d;
   op_class_e op_class;
   logic [1:0] imm_src;
   logic       op_illegal;
   ctrl_t      ctrl;

   instr_decoder u_instr_decoder (
      .op_i       (op),
      .op_class_o (op_class),
      .imm_src_o  (imm_src),
      .illegal_o  (op_illegal)
   );

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op_class)
               OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
               OPC_RTYPE:           state_d = S_EXECUTER;
               OPC_ITYPE:           state_d = S_EXECUTEI;
               OPC_BEQ:             state_d = S_BEQ;
               OPC_JAL:             state_d = S_JAL;
               default:             state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op_class == OPC_LOAD)       state_d = S_MEMREAD;
            else if (op_class == OPC_STORE) state_d = S_MEMWRITE;
            else                            state_d = S_FETCH;
         end
         S_MEMREAD:                     state_d = S_MEMWB;
         S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
         default:                       state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: ctrl = fetch_ctrl();
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src    = 1'b1;
            ctrl.mem_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_EXECUTER: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_update  = 1'b1;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.alu_op     = ALUOP_SUB;
            ctrl.result_src = RES_ALUOUT;
            ctrl.branch     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ;
      endcase
      // Reset is synchronous, so the state may still be mid-instruction here.
      if (reset) ctrl = fetch_ctrl();
   end

   assign pcWrite   = ctrl.pc_update | (ctrl.branch & zero);
   assign adrSrc    = ctrl.adr_src;
   assign memWrite  = ctrl.mem_write;
   assign irWrite   = ctrl.ir_write;
   assign resultSrc = ctrl.result_src;
   assign aluSrcA   = ctrl.alu_src_a;
   assign aluSrcB   = ctrl.alu_src_b;
   assign aluOp     = ctrl.alu_op;
   assign regWrite  = ctrl.reg_write;
   assign instrDone = ctrl.instr_done;
   assign immSrc    = reset ? IMM_I : imm_src;
   assign illegalOp = (state_q == S_DECODE) & op_illegal & ~reset;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: the driver queues one hand-computed
// output vector per cycle, a negedge monitor pops and compares.
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegalOp;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct {
      string       name;
      logic [16:0] v;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [16:0] act;

   always #5 clk = ~clk;

   main_control_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .zero      (zero),
      .pcWrite   (pcWrite),
      .adrSrc    (adrSrc),
      .memWrite  (memWrite),
      .irWrite   (irWrite),
      .resultSrc (resultSrc),
      .aluSrcA   (aluSrcA),
      .aluSrcB   (aluSrcB),
      .aluOp     (aluOp),
      .regWrite  (regWrite),
      .immSrc    (immSrc),
      .instrDone (instrDone),
      .illegalOp (illegalOp)
   );

   // {pcW,adr,memW,irW,resSrc,srcA,srcB,aluOp,regW,imm,done,ill}
   assign act = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                 aluOp, regWrite, immSrc, instrDone, illegalOp};

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if (act !== mon_e.v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", mon_e.name, act, mon_e.v);
         end
      end
   end

   function automatic logic [16:0] ov(input logic pcw, adr, mw, irw,
                                      input logic [1:0] rs, asa, asb, aop,
                                      input logic rw,
                                      input logic [1:0] imm,
                                      input logic done, ill);
      return {pcw, adr, mw, irw, rs, asa, asb, aop, rw, imm, done, ill};
   endfunction

   task automatic step(input string nm, input logic [16:0] v);
      exp_t e;
      e.name = nm;
      e.v    = v;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string nm, input logic [1:0] imm);
      step(nm, ov(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, imm, 1'b0, 1'b0));
   endtask

   task automatic decode(input string nm, input logic [1:0] imm, input logic ill);
      step(nm, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, imm, 1'b0, ill));
   endtask

   logic [16:0] rst_v;
   logic [16:0] memadr_v, memread_v, memwb_v, aluwb_v;

   initial begin
      rst_v      = ov(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      memadr_v   = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      memread_v  = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
      memwb_v    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
      aluwb_v    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);

      reset = 1'b1;
      op    = 7'd0;
      zero  = 1'b0;
      @(posedge clk);
      #1;
      step("reset_c0", rst_v);
      step("reset_c1", rst_v);
      reset = 1'b0;

      op = LW;
      fetch("lw_fetch", 2'b00);
      decode("lw_decode", 2'b00, 1'b0);
      step("lw_memadr", memadr_v);
      step("lw_memread", memread_v);
      step("lw_memwb", memwb_v);

      op = SW;
      fetch("sw_fetch", 2'b01);
      decode("sw_decode", 2'b01, 1'b0);
      step("sw_memadr", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0));
      step("sw_memwrite", ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0));

      op   = BEQ;
      zero = 1'b1;
      fetch("beq_t_fetch", 2'b10);
      decode("beq_t_decode_zero_ignored", 2'b10, 1'b0);
      step("beq_taken", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0));
      zero = 1'b0;
      fetch("beq_n_fetch", 2'b10);
      decode("beq_n_decode", 2'b10, 1'b0);
      step("beq_not_taken", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0));

      op = RT;
      fetch("r_fetch", 2'b00);
      decode("r_decode", 2'b00, 1'b0);
      step("r_execute", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0));
      step("r_aluwb", aluwb_v);

      op = IT;
      fetch("i_fetch", 2'b00);
      decode("i_decode", 2'b00, 1'b0);
      step("i_execute", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0));
      step("i_aluwb", aluwb_v);

      op = JAL;
      fetch("jal_fetch", 2'b11);
      decode("jal_decode", 2'b11, 1'b0);
      step("jal_jal", ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0));
      step("jal_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 1'b1, 1'b0));

      op = BAD;
      fetch("bad_fetch", 2'b00);
      decode("bad_decode_illegal", 2'b00, 1'b1);

      // lw aborted by reset in MEMREAD: no MEMWB may follow.
      op = LW;
      fetch("lw_abort_fetch_after_illegal", 2'b00);
      decode("lw_abort_decode", 2'b00, 1'b0);
      step("lw_abort_memadr", memadr_v);
      reset = 1'b1;
      step("lw_abort_reset_in_memread", rst_v);
      reset = 1'b0;
      fetch("lw_abort_refetch", 2'b00);
      decode("lw_abort_redecode", 2'b00, 1'b0);
      step("lw_abort_memadr2", memadr_v);
      step("lw_abort_memread2", memread_v);
      step("lw_abort_memwb2", memwb_v);

      // op changing after DECODE must not redirect an R-type.
      op = RT;
      fetch("opchg_fetch", 2'b00);
      decode("opchg_decode", 2'b00, 1'b0);
      op = SW;
      step("opchg_execute", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0));
      step("opchg_aluwb", ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0));
      fetch("opchg_back_to_fetch", 2'b01);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle RISC-V main control unit: a Moore FSM that sequences every instruction through fetch, decode, execute, memory and writeback, driving datapath enables and muxes. Its `aluOp` output is the producer side of the `aluOp` interface consumed by `alu_control`. It sits beside `alu_control` in the multicycle core and supports lw, sw, R-type, I-type ALU, beq and jal.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from the instruction register; stable from the cycle after FETCH.
- `zero` in 1: ALU zero flag.
- `pcWrite` out 1: PC register enable.
- `adrSrc` out 1: memory address select (0 = PC, 1 = ALU result register).
- `memWrite` out 1: data memory write enable.
- `irWrite` out 1: instruction register and oldPC enable.
- `resultSrc` out 2: result mux (00 = aluOut register, 01 = data register, 10 = live ALU result).
- `aluSrcA` out 2: ALU A mux (00 = PC, 01 = oldPC, 10 = rs1 register).
- `aluSrcB` out 2: ALU B mux (00 = rs2 register, 01 = immediate, 10 = constant 4).
- `aluOp` out 2: to `alu_control` (00 = add, 01 = subtract/compare, 10 = funct-decoded).
- `regWrite` out 1: register file write enable.
- `immSrc` out 2: immediate format (00 = I, 01 = S, 10 = B, 11 = J).
- `instrDone` out 1: one-cycle pulse in the final state of each instruction.
- `illegalOp` out 1: one-cycle pulse in DECODE when `op` is unsupported.

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- State register only; all outputs decode combinationally from state. Exceptions: `immSrc`, `illegalOp` and the DECODE branch also use `op`; `pcWrite` also uses `zero`.
- `pcWrite = pcUpdate | (branch & zero)`. `pcUpdate` and `branch` are internal.
- Every unlisted signal is 0 in every state.
- FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1. Next state: DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00. Next state by opcode:
  - lw or sw → MEMADR
  - R → EXECUTER
  - I → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - other → FETCH with illegalOp=1 and no architectural write.
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00. Next: MEMWB.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1. Next: FETCH.
- MEMWRITE: adrSrc=1, memWrite=1, instrDone=1. Next: FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Next: ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Next: ALUWB.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Next: ALUWB.
- ALUWB: resultSrc=00, regWrite=1, instrDone=1. Next: FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, instrDone=1. Next: FETCH.
- `immSrc` from `op` in all states: lw/I → 00, sw → 01, beq → 10, jal → 11, other → 00.

## Timing
- Cycles per instruction, FETCH inclusive: lw 5; sw 4; R 4; I 4; jal 4; beq 3; illegal 2.
- `reset` high at a rising edge puts the state in FETCH on the next cycle, from any state, including mid-instruction. The aborted instruction gets no further writes.
- While `reset` is high, outputs show FETCH values: irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10, all else 0. The datapath holds the PC in reset, so these enables are harmless.
- `zero` is used only in BEQ, in the same cycle as the ALU compare; the taken branch updates PC at that cycle's edge.
- `op` changes in any state other than DECODE or MEMADR must not affect the state sequence.

## Structure
- Shared package `riscv_pkg`: opcode localparams, state encoding (4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10), and the aluOp / resultSrc / aluSrcA / aluSrcB / immSrc encodings shared with `alu_control` and the datapath.
- Natural sub-module: `instr_decoder`, combinational `op` → `immSrc` and `illegalOp`. The FSM stays in `main_control_fsm`.

## Test plan
- Reset for 2 cycles, release: state FETCH with irWrite=1, pcWrite=1, aluSrcB=10. The next cycle is DECODE with aluSrcA=01, aluSrcB=01.
- op=0000011 (lw): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regWrite=1 and resultSrc=01 only in cycle 5; instrDone pulses once.
- op=0100011 (sw): memWrite=1 only in cycle 4, with adrSrc=1 and immSrc=01; regWrite stays 0 throughout.
- op=1100011 (beq): with zero=1, pcWrite=1 in cycle 3; with zero=0, pcWrite=0 in cycle 3; aluOp=01 in BEQ. op=0110011 (R): aluOp=10 in cycle 3, regWrite=1 in cycle 4.
- op=1101111 (jal): pcWrite=1 in cycle 3 with aluSrcA=01, aluSrcB=10, immSrc=11; regWrite=1 in cycle 4.
- Edge cases:
  - op=1111111: illegalOp pulses in DECODE, next state FETCH, no regWrite or memWrite.
  - reset asserted during MEMREAD of a lw: the next state is FETCH and MEMWB never occurs.
